// File: rtl/xbar_bypass_pipe_pkg.sv
// SMARTPkg: port index constants, flit type and config FSM states shared by
// the crossbar bypass pipe and its sub-module.
package SMARTPkg;
    localparam int EAST   = 0;
    localparam int SOUTH  = 1;
    localparam int WEST   = 2;
    localparam int NORTH  = 3;
    localparam int ALU_T  = 4;
    localparam int TREG   = 5;
    localparam int FLIT_W = 17;
    typedef logic [FLIT_W-1:0] flit_t;
    typedef enum logic {CFG_IDLE, CFG_PENDING} cfg_state_e;
endpackage

// File: rtl/xbar_bypass_pipe_onehot_detect.sv
// onehot_detect: decodes a select vector into an index plus none/multi-hot flags.
module onehot_detect #(
    parameter  int N  = 6,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          none_o,
    output logic          multi_o
);
    always_comb begin
        idx_o = '0;
        for (int k = 0; k < N; k++)
            if (vec_i[k]) idx_o = IW'(k);
    end
    assign none_o  = ~|vec_i;
    assign multi_o = |(vec_i & (vec_i - 1'b1));
endmodule

// File: rtl/xbar_bypass_pipe.sv
// xbar_bypass_pipe: registered crossbar with per-lane local bypass and
// shadow/active config; XBAR_BYPASS_ERRCNT_EN builds the multi-hot event counter.
module xbar_bypass_pipe
    import SMARTPkg::*;
#(
    parameter  int NUM_IN     = TREG + 1,
    parameter  int NUM_LOCAL  = NORTH + 1,
    parameter  int NUM_OUT    = 7,
    parameter  int FLIT_WIDTH = $bits(flit_t),
    localparam int IW         = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i__cfg_valid,
    input  logic [NUM_OUT-1:0][NUM_IN-1:0]       i__cfg_sel,
    input  logic [NUM_LOCAL-1:0]                 i__cfg_bypass,
    input  logic                                 i__commit,
    output logic                                 o__cfg_pending,
    input  logic [NUM_LOCAL-1:0][FLIT_WIDTH-1:0] i__data_in_local,
    input  logic [NUM_LOCAL-1:0]                 i__valid_local,
    input  logic [NUM_IN-1:0][FLIT_WIDTH-1:0]    i__data_in_remote,
    input  logic [NUM_IN-1:0]                    i__valid_remote,
    output logic [NUM_OUT-1:0][FLIT_WIDTH-1:0]   o__data_out,
    output logic [NUM_OUT-1:0]                   o__valid_out,
    output logic                                 o__sel_err,
    input  logic                                 i__err_clear,
    output logic [7:0]                           o__err_count
);
    cfg_state_e                      state_q, state_d;
    logic [NUM_OUT-1:0][NUM_IN-1:0]  sh_sel_q, sh_sel_d, act_sel_q, act_sel_d;
    logic [NUM_LOCAL-1:0]            sh_byp_q, sh_byp_d, act_byp_q, act_byp_d;
    logic [FLIT_WIDTH-1:0]           eff_data [NUM_IN];
    logic [NUM_IN-1:0]               eff_valid;
    logic [NUM_OUT-1:0][FLIT_WIDTH-1:0] data_d, data_q;
    logic [NUM_OUT-1:0]              hit, multi, valid_q;
    logic                            multi_any, err_q;

    // Commit copies the shadow as it stood before this cycle's write, so a
    // same-cycle write lands in the shadow for the next commit.
    always_comb begin
        sh_sel_d  = i__cfg_valid ? i__cfg_sel : sh_sel_q;
        sh_byp_d  = i__cfg_valid ? i__cfg_bypass : sh_byp_q;
        act_sel_d = (state_q == CFG_PENDING && i__commit) ? sh_sel_q : act_sel_q;
        act_byp_d = (state_q == CFG_PENDING && i__commit) ? sh_byp_q : act_byp_q;
        state_d   = i__cfg_valid ? CFG_PENDING : (i__commit ? CFG_IDLE : state_q);
    end

    for (genvar l = 0; l < NUM_IN; l++) begin : g_lane
        if (l < NUM_LOCAL) begin : g_byp
            assign eff_data[l]  = act_byp_q[l] ? i__data_in_local[l] : i__data_in_remote[l];
            assign eff_valid[l] = act_byp_q[l] ? i__valid_local[l] : i__valid_remote[l];
        end else begin : g_rem
            assign eff_data[l]  = i__data_in_remote[l];
            assign eff_valid[l] = i__valid_remote[l];
        end
    end

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        logic [IW-1:0] idx;
        logic          none;
        onehot_detect #(.N(NUM_IN)) u_det (
            .vec_i  (act_sel_q[o]),
            .idx_o  (idx),
            .none_o (none),
            .multi_o(multi[o])
        );
        assign hit[o]    = ~none & ~multi[o] & eff_valid[idx];
        assign data_d[o] = hit[o] ? eff_data[idx] : '0;
    end

    assign multi_any = |multi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CFG_IDLE;
            sh_sel_q  <= '0;
            sh_byp_q  <= '0;
            act_sel_q <= '0;
            act_byp_q <= '0;
            data_q    <= '0;
            valid_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_sel_q  <= sh_sel_d;
            sh_byp_q  <= sh_byp_d;
            act_sel_q <= act_sel_d;
            act_byp_q <= act_byp_d;
            data_q    <= data_d;
            valid_q   <= hit;
            err_q     <= multi_any | (err_q & ~i__err_clear);
        end
    end

`ifdef XBAR_BYPASS_ERRCNT_EN
    logic [7:0] cnt_q;
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (multi_any)
            cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        else if (i__err_clear)
            cnt_q <= '0;
    end
    assign o__err_count = cnt_q;
`else
    assign o__err_count = '0;
`endif

    assign o__cfg_pending = (state_q == CFG_PENDING);
    assign o__data_out    = data_q;
    assign o__valid_out   = valid_q;
    assign o__sel_err     = err_q;
endmodule
